// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller between event sources and the decoder.
//
// Latches rising edges on NSRC request lines into a pending register, gates
// them with a bus-programmable mask and global enable (gie), and picks the
// lowest-index enabled source. It then raises hold to the decoder, waits for
// holdACK, and keeps EXL high until the ISR writes end-of-interrupt.
//
// Optional feature macro: INT_CTRL_VECTOR_EN
//   defined   -> IV is 1 in REQ and SERVICE (vectored entry, irq_id dispatch)
//   undefined -> IV is tied 0 (single entry point, ISR reads STATUS)
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-low
//   src      in   [NSRC] level request lines; 0->1 is an event
//   we       in   bus write strobe
//   addr     in   [5] bus register address (STATUS=BASE, MASK=BASE+1, EOI=BASE+2)
//   dataIn   in   [32] bus write data
//   rdata    out  [32] combinational read data, 0 for unmapped addresses
//   hold     out  interrupt request to decoder
//   holdACK  in   decoder accepted the request
//   EXL      out  exception level, high while the ISR is in service
//   IV       out  vectored-entry select
//   irq_id   out  [4] source being requested/serviced, 0 when idle
module int_ctrl #(
  parameter int          NSRC = 4,
  parameter logic [4:0]  BASE = 5'b11000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     dataIn,
  output logic [31:0]     rdata,
  output logic            hold,
  input  logic            holdACK,
  output logic            EXL,
  output logic            IV,
  output logic [3:0]      irq_id
);

  localparam logic [4:0] STATUS_A = BASE;
  localparam logic [4:0] MASK_A   = BASE + 5'd1;
  localparam logic [4:0] EOI_A    = BASE + 5'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  logic [NSRC-1:0] src_prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            gie;
  logic [3:0]      id;

  logic [NSRC-1:0] act;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] svc_bit;
  logic [15:0]     pend16;
  logic            eoi_wr;
  logic            mask_wr;

  // Upper data bits other than gie are not stored anywhere.
  logic unused_bits;
  assign unused_bits = ^dataIn[30:NSRC];

  // Fixed priority: lowest set index wins.
  function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign eoi_wr  = we && (addr == EOI_A);
  assign mask_wr = we && (addr == MASK_A);
  assign act     = gie ? (pending & mask) : '0;

  // One-hot of the serviced source; an EOI in SERVICE always retires it.
  always_comb begin
    svc_bit = '0;
    for (int i = 0; i < NSRC; i++) begin
      svc_bit[i] = (id == 4'(i));
    end
  end

  assign clr = eoi_wr ? (dataIn[NSRC-1:0] | ((state == SERVICE) ? svc_bit : '0)) : '0;

  // Edge capture and bus-visible registers. The set term is OR'd after the
  // clear so a new event wins over a same-cycle EOI on that bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '0;
      gie      <= 1'b0;
    end else begin
      src_prev <= src;
      pending  <= (pending & ~clr) | (src & ~src_prev);
      if (mask_wr) begin
        mask <= dataIn[NSRC-1:0];
        gie  <= dataIn[31];
      end
    end
  end

  // Request/service state machine with registered hold/EXL/IV.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      id    <= 4'd0;
      hold  <= 1'b0;
      EXL   <= 1'b0;
`ifdef INT_CTRL_VECTOR_EN
      IV    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (act != '0) begin
            id    <= lowest_idx(act);
            state <= REQ;
            hold  <= 1'b1;
            EXL   <= 1'b0;
`ifdef INT_CTRL_VECTOR_EN
            IV    <= 1'b1;
`endif
          end
        end
        REQ: begin
          // Committed request: id stays frozen regardless of mask/gie changes.
          if (holdACK) begin
            state <= SERVICE;
            hold  <= 1'b0;
            EXL   <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi_wr) begin
            state <= IDLE;
            EXL   <= 1'b0;
`ifdef INT_CTRL_VECTOR_EN
            IV    <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
          EXL   <= 1'b0;
`ifdef INT_CTRL_VECTOR_EN
          IV    <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef INT_CTRL_VECTOR_EN
  assign IV = 1'b0;
`endif

  assign irq_id = (state == IDLE) ? 4'd0 : id;

  always_comb begin
    pend16             = '0;
    pend16[NSRC-1:0]   = pending;
    rdata              = '0;
    if (addr == STATUS_A) begin
      rdata = {gie, state, 13'b0, pend16};
    end else if (addr == MASK_A) begin
      rdata[31]         = gie;
      rdata[NSRC-1:0]   = mask;
    end
  end

endmodule
